// File: rtl/fabric_pkg.sv
// Shared types and defaults for the fabric arbiter slice.
package fabric_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbReq  = 2'd1,
        ArbRsp  = 2'd2,
        ArbErr  = 2'd3
    } arb_state_e;

    localparam int unsigned FABRIC_ADDR_W = 32;
    localparam int unsigned FABRIC_DATA_W = 32;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fabric_arbiter_if.sv
// N-lane request/response bundle; read data and error are shared across lanes.
interface fabric_arbiter_if import fabric_pkg::*; #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = FABRIC_ADDR_W,
    parameter int unsigned DATA_W = FABRIC_DATA_W
);

    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    logic [N-1:0][ADDR_W-1:0] req_addr;
    logic [N-1:0]             req_write;
    logic [N-1:0][DATA_W-1:0] req_wdata;
    logic [N-1:0]             rsp_valid;
    logic [N-1:0]             rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/fabric_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping upward.
module fabric_rr_pick import fabric_pkg::*; #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/fabric_arbiter.sv
// Round-robin arbiter sharing one fabric port among M masters, one transaction
// in flight, with a response watchdog that answers a hung slave locally.
module fabric_arbiter import fabric_pkg::*; #(
    parameter int unsigned M       = 2,
    parameter int unsigned ADDR_W  = FABRIC_ADDR_W,
    parameter int unsigned DATA_W  = FABRIC_DATA_W,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = clog2_min1(TIMEOUT + 1),
    localparam int unsigned IDX_W  = clog2_min1(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    fabric_arbiter_if.slave  m,
    fabric_arbiter_if.master s,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout_pulse
);

    localparam logic [1:0] StIdle = ArbIdle;
    localparam logic [1:0] StReq  = ArbReq;
    localparam logic [1:0] StRsp  = ArbRsp;
    localparam logic [1:0] StErr  = ArbErr;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, ptr_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             req_hs;
    logic             fire;

    fabric_rr_pick #(
        .N     (M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (m.req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign ptr_next = (grant_q == IDX_W'(M - 1)) ? '0 : grant_q + IDX_W'(1);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign req_hs   = m.req_valid[grant_q] && s.req_ready[0];

    // A response arriving on the deadline cycle wins over the watchdog.
    assign fire = (TIMEOUT != 0) && (state_q == StRsp) && !s.rsp_valid[0] &&
                  (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (req_hs) begin
                    cnt_d   = '0;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (s.rsp_valid[0]) begin
                    if (m.rsp_ready[grant_q]) begin
                        ptr_d   = ptr_next;
                        state_d = StIdle;
                    end
                end else if (fire) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StErr: begin
                if (m.rsp_ready[grant_q]) begin
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m.req_ready  = '0;
        m.rsp_valid  = '0;
        m.rsp_rdata  = '0;
        m.rsp_err    = 1'b0;
        s.req_valid  = '0;
        s.req_addr   = '0;
        s.req_write  = '0;
        s.req_wdata  = '0;
        s.rsp_ready  = '0;
        case (state_q)
            // Idle swallows any stale response left over from a reset or timeout.
            StIdle: s.rsp_ready = '1;
            StReq: begin
                s.req_valid[0]       = m.req_valid[grant_q];
                s.req_addr[0]        = m.req_addr[grant_q];
                s.req_write[0]       = m.req_write[grant_q];
                s.req_wdata[0]       = m.req_wdata[grant_q];
                m.req_ready[grant_q] = s.req_ready[0];
            end
            StRsp: begin
                m.rsp_valid[grant_q] = s.rsp_valid[0];
                m.rsp_rdata          = s.rsp_rdata;
                m.rsp_err            = s.rsp_err;
                s.rsp_ready[0]       = m.rsp_ready[grant_q];
            end
            StErr: begin
                m.rsp_valid[grant_q] = 1'b1;
                m.rsp_err            = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_idx     = grant_q;
    assign busy          = (state_q != StIdle);
    assign timeout_pulse = fire;

endmodule

// File: tb/tb_fabric_arbiter.sv
// Directed bench for fabric_arbiter: per-cycle vector table plus a fairness run.
module tb_fabric_arbiter;

    localparam int unsigned M  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam logic [31:0] A0 = 32'h0000_2000;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] W1 = 32'hCAFE_0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] grant_idx;
    logic       busy;
    logic       timeout_pulse;

    always #5 clk = ~clk;

    fabric_arbiter_if #(.N(M), .ADDR_W(AW), .DATA_W(DW)) m_if ();
    fabric_arbiter_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) s_if ();

    fabric_arbiter #(
        .M       (M),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m             (m_if),
        .s             (s_if),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  mrv, mrr;
        logic        sqr, srv;
        logic [31:0] rd;
        logic        serr;
        logic [1:0]  e_mqr, e_mpv;
        logic        e_sqv, e_spr, e_gnt, e_busy, e_to, e_err;
        logic [31:0] e_rd, e_addr;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [1:0] prev_v, prev_r;
    logic       prev_rst;
    logic       have_prev = 1'b0;

    function automatic vec_t v(input logic rst, input logic [1:0] mrv, mrr,
                               input logic sqr, srv, input logic [31:0] rd, input logic serr,
                               input logic [1:0] e_mqr, e_mpv,
                               input logic e_sqv, e_spr, e_gnt, e_busy, e_to, e_err,
                               input logic [31:0] e_rd, e_addr);
        vec_t r;
        r.rst = rst; r.mrv = mrv; r.mrr = mrr; r.sqr = sqr; r.srv = srv;
        r.rd = rd; r.serr = serr; r.e_mqr = e_mqr; r.e_mpv = e_mpv;
        r.e_sqv = e_sqv; r.e_spr = e_spr; r.e_gnt = e_gnt; r.e_busy = e_busy;
        r.e_to = e_to; r.e_err = e_err; r.e_rd = e_rd; r.e_addr = e_addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let outputs settle.
    task automatic drive(input logic rst, input logic [1:0] mrv, mrr, input logic sqr, srv,
                         input logic [31:0] rd, input logic serr);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (have_prev && prev_rst && rst_n && prev_v[i] && !prev_r[i])
                chk($sformatf("hold request m%0d", i), {31'b0, mrv[i]}, 32'd1);
        end
        rst_n              = rst;
        m_if.req_valid     = mrv;
        m_if.rsp_ready     = mrr;
        s_if.req_ready[0]  = sqr;
        s_if.rsp_valid[0]  = srv;
        s_if.rsp_rdata     = rd;
        s_if.rsp_err       = serr;
        #1;
        prev_v    = m_if.req_valid;
        prev_r    = m_if.req_ready;
        prev_rst  = rst_n;
        have_prev = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        logic       exp_g;
        int         got;

        m_if.req_addr[0]  = A0;
        m_if.req_addr[1]  = A1;
        m_if.req_write    = 2'b10;
        m_if.req_wdata[0] = '0;
        m_if.req_wdata[1] = W1;
        m_if.req_valid    = '0;
        m_if.rsp_ready    = '0;
        s_if.req_ready    = '0;
        s_if.rsp_valid    = '0;
        s_if.rsp_rdata    = '0;
        s_if.rsp_err      = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        tbl.push_back(v(0,2'b00,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,0,0,0,0,0,0));
        // Single request from master 1
        tbl.push_back(v(1,2'b10,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,0,0,0,0,0,0));
        tbl.push_back(v(1,2'b10,2'b00,1,0,0,0,                  2'b10,2'b00,1,0,1,1,0,0,0,A1));
        tbl.push_back(v(1,2'b00,2'b10,0,1,32'hA5A5_0001,0,      2'b00,2'b10,0,1,1,1,0,0,32'hA5A5_0001,0));
        tbl.push_back(v(1,2'b00,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,1,0,0,0,0,0));
        // Backpressure: request stalled 5 cycles, response 3 cycles, lands on the deadline
        tbl.push_back(v(1,2'b01,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,1,0,0,0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(v(1,2'b11,2'b00,0,0,0,0,              2'b00,2'b00,1,0,0,1,0,0,0,A0));
        tbl.push_back(v(1,2'b11,2'b00,1,0,0,0,                  2'b01,2'b00,1,0,0,1,0,0,0,A0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(1,2'b10,2'b01,0,0,0,0,              2'b00,2'b00,0,1,0,1,0,0,0,0));
        tbl.push_back(v(1,2'b10,2'b01,0,1,32'h1234_5678,0,      2'b00,2'b01,0,1,0,1,0,0,32'h1234_5678,0));
        // Watchdog on master 1
        tbl.push_back(v(1,2'b10,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,0,0,0,0,0,0));
        tbl.push_back(v(1,2'b10,2'b00,1,0,0,0,                  2'b10,2'b00,1,0,1,1,0,0,0,A1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(1,2'b00,2'b00,0,0,0,0,              2'b00,2'b00,0,0,1,1,0,0,0,0));
        tbl.push_back(v(1,2'b00,2'b00,0,0,0,0,                  2'b00,2'b00,0,0,1,1,1,0,0,0));
        tbl.push_back(v(1,2'b00,2'b00,0,1,32'hDEAD_BEEF,0,      2'b00,2'b10,0,0,1,1,0,1,0,0));
        tbl.push_back(v(1,2'b00,2'b10,0,1,32'hDEAD_BEEF,0,      2'b00,2'b10,0,0,1,1,0,1,0,0));
        tbl.push_back(v(1,2'b00,2'b11,0,1,32'hDEAD_BEEF,0,      2'b00,2'b00,0,1,1,0,0,0,0,0));
        // Error response passes through from the slave
        tbl.push_back(v(1,2'b01,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,1,0,0,0,0,0));
        tbl.push_back(v(1,2'b01,2'b00,1,0,0,0,                  2'b01,2'b00,1,0,0,1,0,0,0,A0));
        tbl.push_back(v(1,2'b00,2'b01,0,1,32'h0000_00C3,1,      2'b00,2'b01,0,1,0,1,0,1,32'h0000_00C3,0));
        // Reset mid-RSP with ptr at 1; afterwards master 0 must win
        tbl.push_back(v(1,2'b10,2'b00,0,0,0,0,                  2'b00,2'b00,0,1,0,0,0,0,0,0));
        tbl.push_back(v(1,2'b10,2'b00,1,0,0,0,                  2'b10,2'b00,1,0,1,1,0,0,0,A1));
        tbl.push_back(v(0,2'b00,2'b10,0,0,0,0,                  2'b00,2'b00,0,1,1,1,0,0,0,0));
        tbl.push_back(v(1,2'b11,2'b11,0,1,32'h0000_5555,0,      2'b00,2'b00,0,1,0,0,0,0,0,0));
        tbl.push_back(v(1,2'b11,2'b00,0,0,0,0,                  2'b00,2'b00,1,0,0,1,0,0,0,A0));
        tbl.push_back(v(1,2'b11,2'b00,1,0,0,0,                  2'b01,2'b00,1,0,0,1,0,0,0,A0));
        tbl.push_back(v(1,2'b10,2'b01,0,1,0,0,                  2'b00,2'b01,0,1,0,1,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].mrv, tbl[i].mrr, tbl[i].sqr, tbl[i].srv,
                  tbl[i].rd, tbl[i].serr);
            chk($sformatf("v%0d m_req_ready", i),   m_if.req_ready,    tbl[i].e_mqr);
            chk($sformatf("v%0d m_rsp_valid", i),   m_if.rsp_valid,    tbl[i].e_mpv);
            chk($sformatf("v%0d s_req_valid", i),   s_if.req_valid,    tbl[i].e_sqv);
            chk($sformatf("v%0d s_rsp_ready", i),   s_if.rsp_ready,    tbl[i].e_spr);
            chk($sformatf("v%0d grant_idx", i),     grant_idx,         tbl[i].e_gnt);
            chk($sformatf("v%0d busy", i),          busy,              tbl[i].e_busy);
            chk($sformatf("v%0d timeout_pulse", i), timeout_pulse,     tbl[i].e_to);
            chk($sformatf("v%0d m_rsp_err", i),     m_if.rsp_err,      tbl[i].e_err);
            chk($sformatf("v%0d m_rsp_rdata", i),   m_if.rsp_rdata,    tbl[i].e_rd);
            chk($sformatf("v%0d s_req_addr", i),    s_if.req_addr[0],  tbl[i].e_addr);
        end

        // Fairness: both masters request continuously from a fresh reset
        drive(0, 2'b11, 2'b11, 1, 1, 32'h77, 0);
        drive(0, 2'b11, 2'b11, 1, 1, 32'h77, 0);
        exp_g = 1'b0;
        got   = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            drive(1, 2'b11, 2'b11, 1, 1, 32'h77, 0);
            if (s_if.req_valid[0] && s_if.req_ready[0]) begin
                chk($sformatf("fair t%0d grant", got), grant_idx, exp_g);
                chk($sformatf("fair t%0d m_req_ready", got), m_if.req_ready,
                    exp_g ? 2'b10 : 2'b01);
                chk($sformatf("fair t%0d s_req_write", got), s_if.req_write, exp_g);
                chk($sformatf("fair t%0d s_req_wdata", got), s_if.req_wdata[0],
                    exp_g ? W1 : 32'h0);
                exp_g = ~exp_g;
                got++;
            end
        end
        chk("fair transaction count", got, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fabric_arbiter.md
# fabric_arbiter

Round-robin arbiter that shares one fabric request/response port between M masters, one outstanding transaction at a time. Sits between the CPU/DMA masters and the address decode stage. It selects a master, forwards its request, returns the response to that master only, and enforces a response watchdog. The watchdog answers a hung slave with a local error response so that no master stalls forever.

## Interface
- `M`, 2: number of masters, ≥1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: cycles to wait in RSP before a local error response; 0 disables the watchdog.
- `CNT_W`, `$clog2(TIMEOUT+1)` (min 1): watchdog counter width.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `m_req_valid`  in  M  per-master request valid.
- `m_req_ready`  out  M  per-master request accept.
- `m_req_addr`  in  M×ADDR_W  request address.
- `m_req_write`  in  M  1 = write.
- `m_req_wdata`  in  M×DATA_W  write data.
- `m_rsp_valid`  out  M  per-master response valid.
- `m_rsp_ready`  in  M  per-master response accept.
- `m_rsp_rdata`  out  DATA_W  shared read data, qualified by `m_rsp_valid`.
- `m_rsp_err`  out  1  shared error flag, qualified by `m_rsp_valid`.
- `s_req_valid` / `s_req_ready`  out/in  1  fabric request handshake.
- `s_req_addr`, `s_req_write`, `s_req_wdata`  out  ADDR_W/1/DATA_W  forwarded request.
- `s_rsp_valid` / `s_rsp_ready`  in/out  1  fabric response handshake.
- `s_rsp_rdata`, `s_rsp_err`  in  DATA_W/1  fabric response.
- `grant_idx`  out  `$clog2(M)` (min 1)  current owner.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_pulse`  out  1  one-cycle strobe when the watchdog fires.

## Operation
- States: IDLE, REQ, RSP, ERR.
- **IDLE**
  - If any `m_req_valid` is high, pick the first requester at or after `ptr` in ascending, wrapping order.
  - Register the pick into `grant_idx` and go to REQ.
  - `s_rsp_ready` is 1 here, so stale slave responses are absorbed and dropped.
- **REQ**
  - `s_req_*` is driven combinationally from master `grant_idx`.
  - `s_req_valid = m_req_valid[grant_idx]` and `m_req_ready[grant_idx] = s_req_ready`.
  - On the `s_req` handshake: clear the counter and go to RSP.
- **RSP**
  - `m_rsp_valid[grant_idx] = s_rsp_valid`; `s_rsp_ready = m_rsp_ready[grant_idx]`; rdata/err pass through.
  - On handshake: `ptr = (grant_idx+1) mod M`, go to IDLE.
  - Otherwise, while `s_rsp_valid` is low, the counter increments each cycle.
  - When the counter reaches `TIMEOUT` (and `TIMEOUT≠0`): pulse `timeout_pulse` and go to ERR.
- **ERR**
  - Drive `m_rsp_valid[grant_idx]=1`, `m_rsp_err=1`, `m_rsp_rdata=0`, `s_rsp_ready=0`.
  - On the master handshake: advance `ptr` and go to IDLE.
- Non-granted masters always see ready=0 and rsp_valid=0.
- Masters must hold the request stable until accepted. Retracting a request is a protocol violation; the bench asserts on it.
- Reset values: state IDLE, `ptr=0`, `grant_idx=0`, counter 0.
  - Every valid/ready output 0, except `s_rsp_ready`, which is 1 because IDLE absorbs.
  - `busy=0`, `timeout_pulse=0`, `m_rsp_err=0`, `m_rsp_rdata=0`, `s_req_*` data 0.
- Reset mid-operation: the next edge returns to IDLE; the in-flight slave response is absorbed in IDLE.
- `M=1`: `grant_idx` stays 0; the state flow is unchanged.

## Timing
- Grant is registered: request seen in cycle 0 gives `s_req_valid` in cycle 1.
- Request and response paths are combinational through the arbiter (no added latency beyond the grant).
- Minimum occupancy is 3 cycles per transaction: IDLE, REQ, RSP.
- The watchdog fires on the `TIMEOUT`-th RSP cycle without `s_rsp_valid`. ERR is entered on the next edge.
- If `s_rsp_valid` rises in the same cycle the counter hits `TIMEOUT`, the real response wins and no timeout occurs.

## Structure
- `fabric_pkg` holds the `arb_state_e` enum (IDLE/REQ/RSP/ERR) and the shared `FABRIC_ADDR_W`/`FABRIC_DATA_W` defaults.
- Sub-module `fabric_rr_pick`: combinational rotate-priority picker.
  - Inputs: `req[M]`, `ptr`.
  - Outputs: `any`, `idx`.
  - Reused by future multi-port arbiters.

## Test plan
- **Single request, M=2.** Master 1 requests addr 0x1000, write; slave ready immediately, response next cycle.
  - `s_req_valid` in cycle 1; master 1 `rsp_valid` in cycle 2; `busy` low in cycle 3.
- **Fairness.** Both masters request continuously.
  - Grants alternate 0,1,0,1 over 8 transactions; neither master is granted twice in a row.
- **Backpressure.** `s_req_ready` low for 5 cycles, then `s_rsp_valid` low for 3 cycles.
  - Request data held stable throughout; exactly one response delivered, to the owner only.
- **Watchdog.** `TIMEOUT=4`; slave never responds.
  - `timeout_pulse` on the 4th RSP cycle; master sees `err=1`, `rdata=0`.
  - A late `s_rsp_valid` in IDLE is absorbed and nothing is forwarded.
- **Reset mid-RSP.** `rst_n` low for 1 cycle during RSP.
  - All outputs at reset values; `ptr=0`; next arbitration grants master 0 first.
